// File: rtl/bram_tdp_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_tdp_port_arbiter
// Description : Round-robin arbiter sharing one true-dual-port, read-first
//               block RAM between NREQ requesters on a single clock. Up to
//               two requests are granted per cycle: the first valid
//               requester in search order gets BRAM port A, the second gets
//               port B. Read data is steered back to its owner one cycle
//               after the accept cycle.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   ARB_ADDR_CONFLICT_EN  when defined, a port-B candidate that targets the
//                         same address as the port-A grant, with at least one
//                         of the two being a write, is deferred one cycle.
//                         When undefined both are granted unconditionally.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          single clock, all logic on posedge
//   rst_n_i        synchronous active-low reset
//   req_valid_i    [NREQ]        requester i has a pending access
//   req_we_i       [NREQ]        1 = write, 0 = read
//   req_addr_i     [NREQ*AW]     word address, requester i at [i*AW +: AW]
//   req_wdata_i    [NREQ*WIDTH]  write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o    [NREQ]        grant this cycle (accept = valid & ready)
//   rsp_valid_o    [NREQ]        read data for requester i valid this cycle
//   rsp_rdata_o    [NREQ*WIDTH]  read data, lane i; unowned lanes drive 0
//   ena_o/enb_o                  BRAM port enables
//   wea_o/web_o                  BRAM write enables
//   addra_o/addrb_o [AW]         BRAM addresses
//   dia_o/dib_o    [WIDTH]       BRAM write data
//   doa_i/dob_i    [WIDTH]       BRAM registered read data (1-cycle latency)
// ============================================================================
module bram_tdp_port_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int SIZE  = 1024,
   parameter  int WIDTH = 16,
   localparam int AW    = $clog2(SIZE)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,

   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ-1:0]       req_we_i,
   input  logic [NREQ*AW-1:0]    req_addr_i,
   input  logic [NREQ*WIDTH-1:0] req_wdata_i,
   output logic [NREQ-1:0]       req_ready_o,

   output logic [NREQ-1:0]       rsp_valid_o,
   output logic [NREQ*WIDTH-1:0] rsp_rdata_o,

   output logic                  ena_o,
   output logic                  wea_o,
   output logic [AW-1:0]         addra_o,
   output logic [WIDTH-1:0]      dia_o,
   input  logic [WIDTH-1:0]      doa_i,

   output logic                  enb_o,
   output logic                  web_o,
   output logic [AW-1:0]         addrb_o,
   output logic [WIDTH-1:0]      dib_o,
   input  logic [WIDTH-1:0]      dob_i
);

   localparam int PW = $clog2(NREQ);

   // -------------------------------------------------------------------------
   // (base + off) mod NREQ. One extra bit holds the intermediate sum, which is
   // at most 2*NREQ-2 for the operands used here, so a single conditional
   // subtract is enough even when NREQ is not a power of two.
   // -------------------------------------------------------------------------
   function automatic logic [PW-1:0] rr_wrap(input logic [PW-1:0] base,
                                             input int             off);
      logic [PW:0] sum;
      sum = {1'b0, base} + (PW+1)'(off);
      if (sum >= (PW+1)'(NREQ)) begin
         sum = sum - (PW+1)'(NREQ);
      end
      return sum[PW-1:0];
   endfunction

   // -------------------------------------------------------------------------
   // Unpack the flattened request buses into per-requester arrays.
   // -------------------------------------------------------------------------
   logic [AW-1:0]    addr_v  [NREQ];
   logic [WIDTH-1:0] wdata_v [NREQ];

   generate
      for (genvar g = 0; g < NREQ; g++) begin : g_unpack
         assign addr_v[g]  = req_addr_i[g*AW +: AW];
         assign wdata_v[g] = req_wdata_i[g*WIDTH +: WIDTH];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Registered state
   // -------------------------------------------------------------------------
   logic [PW-1:0] rr_ptr_q,    rr_ptr_d;
   logic          own_a_vld_q, own_a_vld_d;
   logic [PW-1:0] own_a_idx_q, own_a_idx_d;
   logic          own_b_vld_q, own_b_vld_d;
   logic [PW-1:0] own_b_idx_q, own_b_idx_d;

   // -------------------------------------------------------------------------
   // Candidate search: walk rr_ptr, rr_ptr+1, ... and pick the first two
   // valid requesters. Because each index is visited once, A and B can never
   // name the same requester.
   // -------------------------------------------------------------------------
   logic          found_a, found_b;
   logic [PW-1:0] idx_a,   idx_b;
   logic [PW-1:0] cand;

   always_comb begin
      found_a = 1'b0;
      found_b = 1'b0;
      idx_a   = '0;
      idx_b   = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = rr_wrap(rr_ptr_q, k);
         if (req_valid_i[cand]) begin
            if (!found_a) begin
               found_a = 1'b1;
               idx_a   = cand;
            end else if (!found_b) begin
               found_b = 1'b1;
               idx_b   = cand;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Same-address hazard between the two candidates. A write on one port with
   // any access to the same word on the other has undefined BRAM results, so
   // the optional build holds the port-B candidate back for a cycle.
   // -------------------------------------------------------------------------
   logic conflict;

`ifdef ARB_ADDR_CONFLICT_EN
   assign conflict = found_a && found_b
                     && (addr_v[idx_a] == addr_v[idx_b])
                     && (req_we_i[idx_a] || req_we_i[idx_b]);
`else
   assign conflict = 1'b0;
`endif

   // Grants are suppressed combinationally while reset is held so the BRAM
   // sees no enables and no requester believes it was accepted.
   logic grant_a, grant_b;

   assign grant_a = found_a && rst_n_i;
   assign grant_b = found_b && !conflict && rst_n_i;

   // -------------------------------------------------------------------------
   // Pointer update: move one past the last granted index. B always lies
   // after A in search order, so B wins when granted. A deferred B candidate
   // therefore becomes the head of the next search.
   // -------------------------------------------------------------------------
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_b) begin
         rr_ptr_d = rr_wrap(idx_b, 1);
      end else if (grant_a) begin
         rr_ptr_d = rr_wrap(idx_a, 1);
      end
   end

   // -------------------------------------------------------------------------
   // Ready fan-out: one-hot per port, at most two bits set in total.
   // -------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NREQ; g++) begin : g_ready
         assign req_ready_o[g] = (grant_a && (idx_a == PW'(g)))
                              || (grant_b && (idx_b == PW'(g)));
      end
   endgenerate

   // -------------------------------------------------------------------------
   // BRAM port drive. Address and data are zeroed on an idle port so the
   // memory inputs do not toggle with unrelated requester traffic.
   // -------------------------------------------------------------------------
   assign ena_o   = grant_a;
   assign wea_o   = grant_a && req_we_i[idx_a];
   assign addra_o = grant_a ? addr_v[idx_a]  : '0;
   assign dia_o   = grant_a ? wdata_v[idx_a] : '0;

   assign enb_o   = grant_b;
   assign web_o   = grant_b && req_we_i[idx_b];
   assign addrb_o = grant_b ? addr_v[idx_b]  : '0;
   assign dib_o   = grant_b ? wdata_v[idx_b] : '0;

   // -------------------------------------------------------------------------
   // Read ownership: only reads claim a port's output for the next cycle.
   // The read-first data a write produces is never returned.
   // -------------------------------------------------------------------------
   always_comb begin
      own_a_vld_d = grant_a && !req_we_i[idx_a];
      own_a_idx_d = idx_a;
      own_b_vld_d = grant_b && !req_we_i[idx_b];
      own_b_idx_d = idx_b;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rr_ptr_q    <= '0;
         own_a_vld_q <= 1'b0;
         own_a_idx_q <= '0;
         own_b_vld_q <= 1'b0;
         own_b_idx_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         own_a_vld_q <= own_a_vld_d;
         own_a_idx_q <= own_a_idx_d;
         own_b_vld_q <= own_b_vld_d;
         own_b_idx_q <= own_b_idx_d;
      end
   end

   // -------------------------------------------------------------------------
   // Response routing. Gating with rst_n_i means a read accepted in the cycle
   // just before reset asserts produces no response pulse at all, rather than
   // one that races the reset edge.
   // -------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NREQ; g++) begin : g_rsp
         logic hit_a, hit_b;

         assign hit_a = rst_n_i && own_a_vld_q && (own_a_idx_q == PW'(g));
         assign hit_b = rst_n_i && own_b_vld_q && (own_b_idx_q == PW'(g));

         assign rsp_valid_o[g] = hit_a || hit_b;
         assign rsp_rdata_o[g*WIDTH +: WIDTH] = hit_a ? doa_i :
                                                hit_b ? dob_i : '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_tdp_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_tdp_port_arbiter
// Description : Self-checking bench for bram_tdp_port_arbiter with a
//               behavioural read-first true-dual-port BRAM and a response
//               scoreboard. Honours ARB_ADDR_CONFLICT_EN the same way as the
//               design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bram_tdp_port_arbiter;

   localparam int NREQ  = 4;
   localparam int SIZE  = 1024;
   localparam int WIDTH = 16;
   localparam int AW    = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_we;
   logic [AW-1:0]         t_addr  [NREQ];
   logic [WIDTH-1:0]      t_wdata [NREQ];
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ*WIDTH-1:0] rsp_rdata;
   logic                  ena, wea, enb, web;
   logic [AW-1:0]         addra, addrb;
   logic [WIDTH-1:0]      dia, dib, doa, dob;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW]        = t_addr[i];
         req_wdata[i*WIDTH +: WIDTH] = t_wdata[i];
      end
   end

   bram_tdp_port_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .ena_o       (ena),
      .wea_o       (wea),
      .addra_o     (addra),
      .dia_o       (dia),
      .doa_i       (doa),
      .enb_o       (enb),
      .web_o       (web),
      .addrb_o     (addrb),
      .dib_o       (dib),
      .dob_i       (dob)
   );

   // Behavioural read-first TDP BRAM
   logic [WIDTH-1:0] mem [SIZE];
   always @(posedge clk) begin
      if (ena) begin
         doa <= mem[addra];
         if (wea) mem[addra] <= dia;
      end
      if (enb) begin
         dob <= mem[addrb];
         if (web) mem[addrb] <= dib;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: one entry per expected read response
   typedef struct {
      int               lane;
      int               cyc;
      logic [WIDTH-1:0] data;
      bit               chk;
   } exp_t;
   exp_t exp_q[$];

   task automatic push_exp(input int lane, input logic [WIDTH-1:0] d, input bit chk);
      exp_q.push_back('{lane: lane, cyc: cyc + 1, data: d, chk: chk});
   endtask

   logic [NREQ-1:0]  mon_ev;
   logic [WIDTH-1:0] mon_ed [NREQ];
   bit               mon_ec [NREQ];

   always @(negedge clk) begin
      #2;
      mon_ev = '0;
      for (int i = 0; i < NREQ; i++) begin
         mon_ed[i] = '0;
         mon_ec[i] = 1'b0;
      end
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
         if (exp_q[j].cyc == cyc) begin
            mon_ev[exp_q[j].lane] = 1'b1;
            mon_ed[exp_q[j].lane] = exp_q[j].data;
            mon_ec[exp_q[j].lane] = exp_q[j].chk;
            exp_q.delete(j);
         end else if (exp_q[j].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing lane %0d: got none, expected response at cycle %0d",
                     exp_q[j].lane, exp_q[j].cyc);
            exp_q.delete(j);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (rsp_valid[i] !== mon_ev[i]) begin
            errors++;
            $display("FAIL rsp_valid lane %0d cycle %0d: got %b expected %b",
                     i, cyc, rsp_valid[i], mon_ev[i]);
         end
         if (mon_ev[i] && mon_ec[i]) begin
            checks++;
            if (rsp_rdata[i*WIDTH +: WIDTH] !== mon_ed[i]) begin
               errors++;
               $display("FAIL rsp_rdata lane %0d cycle %0d: got %h expected %h",
                        i, cyc, rsp_rdata[i*WIDTH +: WIDTH], mon_ed[i]);
            end
         end else if (!mon_ev[i]) begin
            checks++;
            if (rsp_rdata[i*WIDTH +: WIDTH] !== '0) begin
               errors++;
               $display("FAIL rsp_idle_zero lane %0d cycle %0d: got %h expected 0",
                        i, cyc, rsp_rdata[i*WIDTH +: WIDTH]);
            end
         end
      end
   end

   // Stimulus helpers
   task automatic set_req(input int i, input logic we, input int addr, input logic [WIDTH-1:0] d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      t_addr[i]    = AW'(addr);
      t_wdata[i]   = d;
   endtask

   task automatic clr_req();
      req_valid = '0;
      req_we    = '0;
      for (int i = 0; i < NREQ; i++) begin
         t_addr[i]  = '0;
         t_wdata[i] = '0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clr_req();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // 1: reset holds everything idle, then grants start from requester 0
   task automatic test_reset();
      rst_n = 1'b0;
      clr_req();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 100 + i, '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (req_ready !== 4'b0000 || ena !== 1'b0 || enb !== 1'b0 || wea !== 1'b0 || web !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle c%0d: got ready=%b ena=%b enb=%b wea=%b web=%b expected all 0",
                     c, req_ready, ena, enb, wea, web);
         end
         checks++;
         if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rsp c%0d: got %b expected 0000", c, rsp_valid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0011 || ena !== 1'b1 || enb !== 1'b1 || addra !== AW'(100) || addrb !== AW'(101)) begin
         errors++;
         $display("FAIL reset_release: got ready=%b ena=%b enb=%b addra=%0d addrb=%0d expected 0011 1 1 100 101",
                  req_ready, ena, enb, addra, addrb);
      end
      push_exp(0, '0, 1'b0);
      push_exp(1, '0, 1'b0);
      @(negedge clk);
      clr_req();
   endtask

   // 2: write then read back on requester 0, 1-cycle latency
   task automatic test_write_read();
      apply_reset();
      @(negedge clk);
      set_req(0, 1'b1, 5, 16'hBEEF);
      #1;
      checks++;
      if (req_ready !== 4'b0001 || ena !== 1'b1 || wea !== 1'b1 || addra !== AW'(5) || dia !== 16'hBEEF || enb !== 1'b0) begin
         errors++;
         $display("FAIL wr_grant: got ready=%b ena=%b wea=%b addra=%0d dia=%h enb=%b expected 0001 1 1 5 beef 0",
                  req_ready, ena, wea, addra, dia, enb);
      end
      @(negedge clk);
      set_req(0, 1'b0, 5, '0);
      #1;
      checks++;
      if (req_ready !== 4'b0001 || ena !== 1'b1 || wea !== 1'b0 || addra !== AW'(5)) begin
         errors++;
         $display("FAIL rd_grant: got ready=%b ena=%b wea=%b addra=%0d expected 0001 1 0 5",
                  req_ready, ena, wea, addra);
      end
      push_exp(0, 16'hBEEF, 1'b1);
      @(negedge clk);
      clr_req();
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_rdata[0 +: WIDTH] !== 16'hBEEF) begin
         errors++;
         $display("FAIL rd_latency: got valid=%b data=%h expected 0001 beef",
                  rsp_valid, rsp_rdata[0 +: WIDTH]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++;
         $display("FAIL rd_single_pulse: got %b expected 0000", rsp_valid);
      end
   endtask

   // 3: round-robin rotation, wrap, single requester and idle hold
   task automatic test_round_robin();
      logic [NREQ-1:0] exp_rdy;
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 40 + i, WIDTH'(16'hA000 + c*16 + i));
         #1;
         exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
         checks++;
         if (req_ready !== exp_rdy || addra !== AW'(40 + (c % 2)*2) || addrb !== AW'(41 + (c % 2)*2)) begin
            errors++;
            $display("FAIL rr_pairs c%0d: got ready=%b addra=%0d addrb=%0d expected %b %0d %0d",
                     c, req_ready, addra, addrb, exp_rdy, 40 + (c % 2)*2, 41 + (c % 2)*2);
         end
      end
      // Pointer is 0 here; a lone requester 3 takes A and wraps pointer to 0
      @(negedge clk);
      clr_req();
      set_req(3, 1'b1, 60, 16'h0003);
      #1;
      checks++;
      if (req_ready !== 4'b1000 || ena !== 1'b1 || enb !== 1'b0 || addra !== AW'(60)) begin
         errors++;
         $display("FAIL rr_single: got ready=%b ena=%b enb=%b addra=%0d expected 1000 1 0 60",
                  req_ready, ena, enb, addra);
      end
      @(negedge clk);
      clr_req();
      #1;
      checks++;
      if (req_ready !== 4'b0000 || ena !== 1'b0 || enb !== 1'b0) begin
         errors++;
         $display("FAIL rr_none: got ready=%b ena=%b enb=%b expected 0000 0 0", req_ready, ena, enb);
      end
      @(negedge clk);
      set_req(0, 1'b1, 61, 16'h0010);
      set_req(3, 1'b1, 62, 16'h0013);
      #1;
      checks++;
      if (req_ready !== 4'b1001 || addra !== AW'(61) || addrb !== AW'(62)) begin
         errors++;
         $display("FAIL rr_wrap: got ready=%b addra=%0d addrb=%0d expected 1001 61 62",
                  req_ready, addra, addrb);
      end
      @(negedge clk);
      clr_req();
   endtask

   // 4: two reads on both ports with pointer at 2
   task automatic test_dual_read();
      apply_reset();
      @(negedge clk);
      set_req(0, 1'b1, 7, 16'h1111);
      set_req(1, 1'b1, 9, 16'h2222);
      #1;
      checks++;
      if (req_ready !== 4'b0011) begin
         errors++;
         $display("FAIL dual_preload: got ready=%b expected 0011", req_ready);
      end
      @(negedge clk);
      clr_req();
      set_req(3, 1'b0, 7, '0);
      set_req(1, 1'b0, 9, '0);
      #1;
      checks++;
      if (req_ready !== 4'b1010 || addra !== AW'(7) || addrb !== AW'(9) || wea !== 1'b0 || web !== 1'b0) begin
         errors++;
         $display("FAIL dual_grant: got ready=%b addra=%0d addrb=%0d wea=%b web=%b expected 1010 7 9 0 0",
                  req_ready, addra, addrb, wea, web);
      end
      push_exp(3, 16'h1111, 1'b1);
      push_exp(1, 16'h2222, 1'b1);
      @(negedge clk);
      clr_req();
      #1;
      checks++;
      if (rsp_rdata[3*WIDTH +: WIDTH] !== 16'h1111 || rsp_rdata[1*WIDTH +: WIDTH] !== 16'h2222) begin
         errors++;
         $display("FAIL dual_data: got lane3=%h lane1=%h expected 1111 2222",
                  rsp_rdata[3*WIDTH +: WIDTH], rsp_rdata[1*WIDTH +: WIDTH]);
      end
      @(negedge clk);
   endtask

   // 5: same-address write/read in one cycle
   task automatic test_conflict();
      apply_reset();
      @(negedge clk);
      set_req(0, 1'b1, 3, 16'h5A5A);
      set_req(1, 1'b0, 3, '0);
      #1;
`ifdef ARB_ADDR_CONFLICT_EN
      checks++;
      if (req_ready !== 4'b0001 || enb !== 1'b0 || wea !== 1'b1) begin
         errors++;
         $display("FAIL conflict_defer: got ready=%b enb=%b wea=%b expected 0001 0 1", req_ready, enb, wea);
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0010 || ena !== 1'b1 || wea !== 1'b0 || addra !== AW'(3)) begin
         errors++;
         $display("FAIL conflict_retry: got ready=%b ena=%b wea=%b addra=%0d expected 0010 1 0 3",
                  req_ready, ena, wea, addra);
      end
      push_exp(1, 16'h5A5A, 1'b1);
`else
      checks++;
      if (req_ready !== 4'b0011 || ena !== 1'b1 || enb !== 1'b1) begin
         errors++;
         $display("FAIL conflict_both: got ready=%b ena=%b enb=%b expected 0011 1 1", req_ready, ena, enb);
      end
      push_exp(1, '0, 1'b0);
`endif
      @(negedge clk);
      clr_req();
      @(negedge clk);
   endtask

   // 6: reset one cycle after a read accept swallows the response
   task automatic test_midflight_reset();
      apply_reset();
      @(negedge clk);
      set_req(2, 1'b0, 5, '0);
      #1;
      checks++;
      if (req_ready !== 4'b0100 || ena !== 1'b1) begin
         errors++;
         $display("FAIL mid_accept: got ready=%b ena=%b expected 0100 1", req_ready, ena);
      end
      @(negedge clk);
      clr_req();
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 4'b0000 || rsp_rdata !== '0) begin
         errors++;
         $display("FAIL mid_no_rsp: got valid=%b data=%h expected 0000 0", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 200 + i, '0);
      #1;
      checks++;
      if (req_ready !== 4'b0011 || addra !== AW'(200) || addrb !== AW'(201)) begin
         errors++;
         $display("FAIL mid_resume: got ready=%b addra=%0d addrb=%0d expected 0011 200 201",
                  req_ready, addra, addrb);
      end
      push_exp(0, '0, 1'b0);
      push_exp(1, '0, 1'b0);
      @(negedge clk);
      clr_req();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_dual_read();
      test_conflict();
      test_midflight_reset();
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
